// File: rtl/multi_spinner.sv
// multi_spinner: per-channel position accumulator that merges accelerated plus/minus
// buttons with spinner deltas, and latches each position to spin_out on a rising strobe.
module multi_spinner #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int TICK_DIV    = 400000,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 8,
  parameter int ACCEL_TICKS = 4,
  parameter int CENTER      = 2**(WIDTH-1),
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 2**WIDTH-1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      strobe,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [9*CHANNELS-1:0]     spin_in,
  input  logic [2*CHANNELS-1:0]     mode,
  output logic [WIDTH*CHANNELS-1:0] spin_out,
  output logic [CHANNELS-1:0]       moved
);
  localparam int SW = WIDTH + 10;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]          PRESC_TOP = PW'(TICK_DIV - 1);
  localparam logic [7:0]             S_MIN     = 8'(STEP_MIN);
  localparam logic [7:0]             S_MAX     = 8'(STEP_MAX);
  localparam logic [7:0]             A_TOP     = 8'(ACCEL_TICKS);
  localparam logic signed [SW-1:0]   LO        = SW'(MIN_VAL);
  localparam logic signed [SW-1:0]   HI        = SW'(MAX_VAL);
  localparam logic signed [SW-1:0]   CEN       = SW'(CENTER);
  localparam logic signed [SW-1:0]   S_MIN_S   = SW'(STEP_MIN);
  localparam logic [WIDTH-1:0]       CEN_U     = WIDTH'(CENTER);
  localparam logic [1:0] M_WRAP = 2'd0, M_CLAMP = 2'd1, M_CENTRE = 2'd2, M_HOLD = 2'd3;

  logic [PW-1:0] presc;
  logic          tick, strobe_d, primed, latch;

  // Down-counting prescaler; terminal count at zero gives the same tick phase as 0..TICK_DIV-1.
  assign tick  = (presc == '0);
  assign latch = strobe & ~strobe_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= PRESC_TOP;
      strobe_d <= 1'b0;
      primed   <= 1'b0;
    end else begin
      presc    <= tick ? PRESC_TOP : presc - 1'b1;
      strobe_d <= strobe;
      primed   <= 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0]       pos, pos_nxt, out_q;
    logic                   moved_q, tog_q, dir_q, dir_nxt;
    logic [7:0]             step, step_nxt, cnt, cnt_nxt, eff_step, cnt_inc;
    logic [7:0]             delta;
    logic                   tog, ev, up, dn;
    logic [1:0]             md;
    logic signed [SW-1:0]   mv, dv, sum, sat;

    assign {tog, delta} = spin_in[9*g +: 9];
    assign md = mode[2*g +: 2];
    assign ev = primed & (tog ^ tog_q);
    assign up = plus[g] & ~minus[g];
    assign dn = minus[g] & ~plus[g];

    always_comb begin
      step_nxt = step;
      cnt_nxt  = cnt;
      dir_nxt  = dir_q;
      eff_step = step;
      cnt_inc  = '0;
      mv       = '0;
      if (tick) begin
        if ((up | dn) && md != M_HOLD) begin
          // a reversal restarts acceleration before this tick's move
          eff_step = (up != dir_q) ? S_MIN : step;
          cnt_inc  = ((up != dir_q) ? 8'd0 : cnt) + 8'd1;
          mv       = SW'(eff_step);
          if (dn) mv = -mv;
          dir_nxt  = up;
          if (cnt_inc == A_TOP) begin
            step_nxt = (eff_step < S_MAX) ? eff_step + 8'd1 : S_MAX;
            cnt_nxt  = '0;
          end else begin
            step_nxt = eff_step;
            cnt_nxt  = cnt_inc;
          end
        end else begin
          step_nxt = S_MIN;
          cnt_nxt  = '0;
        end
      end
      dv  = ev ? SW'($signed(delta)) : '0;
      sum = $signed(SW'(pos)) + mv + dv;
      if (sum < LO)      sat = LO;
      else if (sum > HI) sat = HI;
      else               sat = sum;
      if (md == M_CENTRE && tick && !(plus[g] | minus[g]) && !ev) begin
        if (sat < CEN)      sat = (sat + S_MIN_S > CEN) ? CEN : sat + S_MIN_S;
        else if (sat > CEN) sat = (sat - S_MIN_S < CEN) ? CEN : sat - S_MIN_S;
      end
      pos_nxt = pos;
      case (md)
        M_WRAP:            pos_nxt = sum[WIDTH-1:0];
        M_CLAMP, M_CENTRE: pos_nxt = sat[WIDTH-1:0];
        default:           pos_nxt = pos;
      endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        pos     <= CEN_U;
        out_q   <= CEN_U;
        moved_q <= 1'b0;
        tog_q   <= 1'b0;
        dir_q   <= 1'b0;
        step    <= S_MIN;
        cnt     <= '0;
      end else begin
        pos   <= pos_nxt;
        tog_q <= tog;
        step  <= step_nxt;
        cnt   <= cnt_nxt;
        dir_q <= dir_nxt;
        if (latch) begin
          out_q   <= pos;
          moved_q <= (pos != out_q);
        end else begin
          moved_q <= 1'b0;
        end
      end
    end

    assign spin_out[g*WIDTH +: WIDTH] = out_q;
    assign moved[g] = moved_q;
  end
endmodule

// File: tb/tb_multi_spinner.sv
// Bench for multi_spinner: directed vector table and corner sequences, then random
// stimulus, all checked each cycle against an integer behavioural model.
module tb_multi_spinner;
  localparam int CH = 2, W = 8, TD = 4, SMIN = 1, SMAX = 3, AT = 2;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              strobe  = 1'b0;
  logic [CH-1:0]     plus    = '0;
  logic [CH-1:0]     minus   = '0;
  logic [9*CH-1:0]   spin_in = '0;
  logic [2*CH-1:0]   mode    = '0;
  logic [W*CH-1:0]   spin_out;
  logic [CH-1:0]     moved;

  int n_checks = 0, n_fail = 0;

  multi_spinner #(.CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .STEP_MIN(SMIN),
                  .STEP_MAX(SMAX), .ACCEL_TICKS(AT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .strobe(strobe), .plus(plus),
    .minus(minus), .spin_in(spin_in), .mode(mode), .spin_out(spin_out), .moved(moved));

  always #5 clk_sys = ~clk_sys;

  // behavioural model state
  int  m_pos[CH], m_out[CH], m_step[CH], m_cnt[CH], m_dir[CH];
  bit  m_mv[CH], m_tog[CH];
  bit  m_primed, m_sd;
  int  m_cyc;

  typedef struct {
    bit         ev;
    logic [7:0] d;
    logic [1:0] md;
    bit         stb;
    logic [7:0] exp_out;
    bit         exp_mv;
  } vec_t;
  vec_t tbl[18];
  logic [7:0] cexp[4];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 128; m_out[c] = 128; m_mv[c] = 0; m_tog[c] = 0;
      m_step[c] = SMIN; m_cnt[c] = 0; m_dir[c] = 0;
    end
    m_primed = 0; m_sd = 0; m_cyc = 0;
  endfunction

  function automatic void model_clock();
    bit tick   = (m_cyc % TD) == TD - 1;
    bit edge_s = strobe && !m_sd;
    for (int c = 0; c < CH; c++) begin
      int  old  = m_pos[c];
      bit  tg   = spin_in[9*c+8];
      byte d8   = spin_in[9*c +: 8];
      int  d    = d8;
      bit  ev   = m_primed && (tg != m_tog[c]);
      int  md   = mode[2*c +: 2];
      bit  p    = plus[c];
      bit  mi   = minus[c];
      int  move = 0;
      int  sum, s, dir;
      if (edge_s) begin
        m_mv[c] = (old != m_out[c]);
        m_out[c] = old;
      end else m_mv[c] = 0;
      m_tog[c] = tg;
      if (tick) begin
        if (md != 3 && p != mi) begin
          dir = p ? 1 : -1;
          if (dir != m_dir[c]) begin m_step[c] = SMIN; m_cnt[c] = 0; end
          move = dir * m_step[c];
          m_dir[c] = dir;
          m_cnt[c]++;
          if (m_cnt[c] == AT) begin
            m_step[c] = (m_step[c] + 1 > SMAX) ? SMAX : m_step[c] + 1;
            m_cnt[c] = 0;
          end
        end else begin
          m_step[c] = SMIN; m_cnt[c] = 0; m_dir[c] = 0;
        end
      end
      sum = old + move + (ev ? d : 0);
      if (md == 0) m_pos[c] = sum & (2**W - 1);
      else if (md == 1 || md == 2) begin
        s = (sum < 0) ? 0 : (sum > 2**W - 1) ? 2**W - 1 : sum;
        if (md == 2 && tick && !p && !mi && !ev) begin
          if (s < 128) s = s + 1;
          else if (s > 128) s = s - 1;
        end
        m_pos[c] = s;
      end
    end
    m_sd = strobe;
    m_primed = 1;
    m_cyc++;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model spin_out[%0d]", c), 32'(spin_out[W*c +: W]), 32'(m_out[c]));
      check($sformatf("model moved[%0d]", c), 32'(moved[c]), 32'(m_mv[c]));
    end
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk_sys);
    #1;
    check_outputs();
  endtask

  task automatic event0(input logic [7:0] d);
    spin_in[8:0] = {~spin_in[8], d};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'h7F, 2'd0, 1'b0, 8'h80, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 2'd0, 1'b0, 8'h80, 1'b0};
    tbl[2]  = '{1'b0, 8'h01, 2'd0, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 8'h01, 2'd0, 1'b1, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 8'h01, 2'd0, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h80, 2'd0, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h80, 2'd0, 1'b1, 8'h80, 1'b1};
    tbl[7]  = '{1'b0, 8'h80, 2'd0, 1'b0, 8'h80, 1'b0};
    tbl[8]  = '{1'b1, 8'h7F, 2'd1, 1'b0, 8'h80, 1'b0};
    tbl[9]  = '{1'b1, 8'h7F, 2'd1, 1'b0, 8'h80, 1'b0};
    tbl[10] = '{1'b0, 8'h7F, 2'd1, 1'b1, 8'hFF, 1'b1};
    tbl[11] = '{1'b1, 8'h80, 2'd1, 1'b0, 8'hFF, 1'b0};
    tbl[12] = '{1'b1, 8'h80, 2'd1, 1'b0, 8'hFF, 1'b0};
    tbl[13] = '{1'b1, 8'h80, 2'd1, 1'b0, 8'hFF, 1'b0};
    tbl[14] = '{1'b0, 8'h80, 2'd1, 1'b1, 8'h00, 1'b1};
    tbl[15] = '{1'b0, 8'h80, 2'd1, 1'b0, 8'h00, 1'b0};
    tbl[16] = '{1'b0, 8'h80, 2'd1, 1'b1, 8'h00, 1'b0};
    tbl[17] = '{1'b0, 8'h80, 2'd1, 1'b0, 8'h00, 1'b0};
    cexp = '{8'h82, 8'h81, 8'h80, 8'h80};

    // reset asserted mid plus-hold clears outputs without a clock
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    plus = 2'b11;
    repeat (10) cycle();
    strobe = 1'b1; cycle();
    strobe = 1'b0; cycle();
    #3 reset_n = 1'b0;
    #1;
    check("async reset spin_out", 32'(spin_out), 32'h8080);
    check("async reset moved", 32'(moved), 32'h0);
    model_reset();
    plus = '0;
    spin_in = {1'b1, 8'h10, 1'b1, 8'h10};
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (3) cycle();
    strobe = 1'b1; cycle();
    check("no replay after reset", 32'(spin_out), 32'h8080);
    strobe = 1'b0; cycle();

    // wrap and clamp vectors on channel 0, channel 1 held
    mode[3:2] = 2'd3;
    for (int i = 0; i < 18; i++) begin
      spin_in[8:0] = {tbl[i].ev ? ~spin_in[8] : spin_in[8], tbl[i].d};
      mode[1:0] = tbl[i].md;
      strobe = tbl[i].stb;
      cycle();
      check($sformatf("vec%0d spin_out", i), 32'(spin_out[7:0]), 32'(tbl[i].exp_out));
      check($sformatf("vec%0d moved", i), 32'(moved[0]), 32'(tbl[i].exp_mv));
    end
    strobe = 1'b0;

    // acceleration: 7 ticks of plus then one of minus
    mode[1:0] = 2'd0;
    event0(8'h80); cycle();
    while (m_cyc % TD != 0) cycle();
    plus[0] = 1'b1;
    repeat (28) cycle();
    plus[0] = 1'b0; strobe = 1'b1; cycle();
    check("accel 7 ticks", 32'(spin_out[7:0]), 32'h8F);
    strobe = 1'b0; minus[0] = 1'b1;
    repeat (4) cycle();
    minus[0] = 1'b0; strobe = 1'b1; cycle();
    check("reversal step", 32'(spin_out[7:0]), 32'h8E);
    strobe = 1'b0; cycle();

    // centre mode return
    mode[1:0] = 2'd1;
    event0(8'hF5); cycle();
    while (m_cyc % TD != 0) cycle();
    mode[1:0] = 2'd2;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      strobe = 1'b1; cycle();
      check($sformatf("centre step %0d", i), 32'(spin_out[7:0]), 32'(cexp[i]));
      strobe = 1'b0; repeat (3) cycle();
    end

    // tick, plus, event and strobe edge together
    mode[1:0] = 2'd0;
    while (m_cyc % TD != TD - 1) cycle();
    plus[0] = 1'b1; event0(8'h05); strobe = 1'b1;
    cycle();
    check("coincide pre-update out", 32'(spin_out[7:0]), 32'h80);
    check("coincide moved", 32'(moved[0]), 32'h0);
    plus[0] = 1'b0; strobe = 1'b0; cycle();
    strobe = 1'b1; cycle();
    check("coincide new out", 32'(spin_out[7:0]), 32'h86);
    check("coincide moved next", 32'(moved[0]), 32'h1);
    strobe = 1'b0; cycle();

    // random phase
    mode = '0;
    repeat (1500) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          plus[c]  = 1'($urandom_range(0, 1));
          minus[c] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 59) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) spin_in[9*c +: 9] = {~spin_in[9*c+8], 8'($urandom)};
      end
      strobe = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
